noise_sequencer: RTL and testbench
==================================

NOISE_SEQUENCER -- requirements
Module: noise_sequencer

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a burst; honoured only in IDLE.
REQ-005 cfg_mode  input  2  noise policy: 0 OFF, 1 FIXED, 2 SWEEP, 3 RANDOM.
REQ-006 cfg_fixed  input  5  noise code used in FIXED mode.
REQ-007 cfg_burst  input  8  number of codewords per burst; 0 means 256.
REQ-008 in_valid / in_ready  input / output  1 / 1  upstream codeword handshake.
REQ-009 in_data  input  8  Hamming(7,4)+parity codeword.
REQ-010 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-011 out_data  output  8  accepted codeword, unmodified.
REQ-012 out_noise  output  5  noise code paired with out_data, for the downstream noise-injection stage (bits [2:0] position, [3] extra bit, [4] MSB flip).
REQ-013 busy  output  1  high in RUN and DRAIN.
REQ-014 done  output  1  one-cycle pulse on burst completion.
REQ-015 remaining  output  8  codewords still to accept in the current burst.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start.
- RUN -> DRAIN when the last codeword of the burst is accepted.
- DRAIN -> DONE when the output register is empty.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 cfg_mode, cfg_fixed and cfg_burst SHALL be sampled on the start cycle and held for the whole burst.
REQ-018 in_ready SHALL be high only in RUN, and only when (!out_valid || out_ready).
REQ-019 The single output register SHALL load on an input handshake: out_data = in_data, out_noise = the code for the current policy, out_valid = 1, one cycle of latency.
- Simultaneous load and drain SHALL sustain full throughput of one codeword per cycle.
REQ-020 out_valid SHALL clear on (out_valid && out_ready) with no new load; out_data and out_noise SHALL stay stable while out_valid && !out_ready.
REQ-021 Code per policy:
- OFF: 5'd0.
- FIXED: cfg_fixed.
- SWEEP: 5-bit counter value, then increment; wraps 31 -> 0.
- RANDOM: lfsr[4:0], then advance the LFSR.
REQ-022 The sweep counter and the LFSR SHALL advance only on an input handshake.
REQ-023 remaining SHALL load on start (0 loads as 256, reads as 8'd0) and decrement per handshake; the transition to DRAIN occurs on the handshake made while remaining == 1.
REQ-024 start asserted outside IDLE SHALL be ignored, with no state or counter change.
REQ-025 done SHALL be high exactly in the DONE state; busy SHALL be low in IDLE and DONE.

Reset
REQ-026 rst SHALL force IDLE, in_ready=0, out_valid=0, out_data=0, out_noise=0, busy=0, done=0, remaining=0, sweep counter=0, LFSR=8'hA5, taking effect immediately, including mid-burst; an in-flight codeword is discarded.

Configuration
REQ-027 Macro NOISE_SEQ_LFSR_EN:
- Defined: RANDOM mode uses an 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1, reseeded to 8'hA5 on every start.
- Undefined: no LFSR logic exists and RANDOM behaves exactly as SWEEP.

Structure
REQ-028 Shared package hamming_pkg SHALL hold the noise-mode enum, NOISE_W=5, CW_W=8 and LFSR_SEED=8'hA5.
REQ-029 The LFSR SHALL be the sub-module noise_lfsr (ports clk, rst, load, step, state[7:0]), instantiated only under NOISE_SEQ_LFSR_EN.

Verification
REQ-030 FIXED, cfg_fixed=5'h13, cfg_burst=3, out_ready=1, three back-to-back words -> out_noise=5'h13 ×3, in_ready low from the cycle after the third handshake, done pulses once, back in IDLE.
REQ-031 SWEEP, cfg_burst=0, 256 words -> codes 0..31 repeating eight times, wrap 31->0 observed, done after the 256th output.
REQ-032 out_ready held low for 5 cycles with out_valid=1 -> in_ready=0, out_data/out_noise stable; releasing gives one transfer per cycle with no loss or duplication.
REQ-033 start pulsed during RUN -> ignored; remaining unchanged.
REQ-034 rst asserted mid-burst with out_valid=1 -> out_valid=0 and IDLE immediately; a new start with cfg_burst=2 completes normally from sweep code 0.
REQ-035 RANDOM with NOISE_SEQ_LFSR_EN, cfg_burst=4 -> codes equal to successive low 5 bits of the LFSR sequence from seed A5; without the macro -> codes 0,1,2,3.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and constants for the noise sequencer slice.
// Optional feature macro used by this slice: NOISE_SEQ_LFSR_EN (LFSR-driven RANDOM mode).
package hamming_pkg;

  localparam int NOISE_W = 5;
  localparam int CW_W    = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_SWEEP  = 2'd2,
    MODE_RANDOM = 2'd3
  } noise_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/noise_sequencer_if.sv
// Control, configuration and codeword stream signals of the noise sequencer.
// master = the side that issues bursts and codewords; slave = the sequencer.
interface noise_sequencer_if;
  import hamming_pkg::*;

  logic               start;
  logic [1:0]         cfg_mode;
  logic [NOISE_W-1:0] cfg_fixed;
  logic [7:0]         cfg_burst;
  logic               in_valid;
  logic               in_ready;
  logic [CW_W-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [CW_W-1:0]    out_data;
  logic [NOISE_W-1:0] out_noise;
  logic               busy;
  logic               done;
  logic [7:0]         remaining;

  modport master (
    output start, cfg_mode, cfg_fixed, cfg_burst, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_noise, busy, done, remaining
  );

  modport slave (
    input  start, cfg_mode, cfg_fixed, cfg_burst, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_noise, busy, done, remaining
  );

endinterface

// File: rtl/noise_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded with LFSR_SEED.
// Only instantiated when NOISE_SEQ_LFSR_EN is defined.
module noise_lfsr
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] state
);

  // Reseed on load, otherwise shift left feeding back taps 8,6,5,4.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (load) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/noise_sequencer.sv
// Burst sequencer pairing each accepted codeword with a noise code.
// Optional feature macro: NOISE_SEQ_LFSR_EN -- when defined, RANDOM mode draws
// codes from an LFSR; when undefined, RANDOM behaves exactly as SWEEP.
module noise_sequencer
  import hamming_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  noise_sequencer_if.slave bus
);

  seq_state_e         state_q, state_d;
  noise_mode_e        mode_q;
  logic [NOISE_W-1:0] fixed_q;
  logic [NOISE_W-1:0] sweep_q;
  logic [NOISE_W-1:0] noise_code;
  logic [7:0]         rem_q;
  logic               valid_q;
  logic [CW_W-1:0]    data_q;
  logic [NOISE_W-1:0] noise_q;
  logic               in_ready;
  logic               hs;
  logic               accept_start;
  logic               sweep_step;

  assign accept_start = (state_q == ST_IDLE) && bus.start;
  // Output register frees up this cycle if empty or being drained.
  assign in_ready     = (state_q == ST_RUN) && (!valid_q || bus.out_ready);
  assign hs           = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_noise = noise_q;
  assign bus.remaining = rem_q;

`ifdef NOISE_SEQ_LFSR_EN
  logic [7:0] lfsr_state;

  assign sweep_step = hs && (mode_q == MODE_SWEEP);

  noise_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_start),
    .step  (hs && (mode_q == MODE_RANDOM)),
    .state (lfsr_state)
  );
`else
  assign sweep_step = hs && ((mode_q == MODE_SWEEP) || (mode_q == MODE_RANDOM));
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and status outputs.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        bus.busy = 1'b1;
        if (hs && (rem_q == 8'd1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        bus.busy = 1'b1;
        if (!valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Noise code selected by the latched policy.
  always_comb begin
    noise_code = '0;
    case (mode_q)
      MODE_OFF:    noise_code = '0;
      MODE_FIXED:  noise_code = fixed_q;
      MODE_SWEEP:  noise_code = sweep_q;
`ifdef NOISE_SEQ_LFSR_EN
      MODE_RANDOM: noise_code = lfsr_state[NOISE_W-1:0];
`else
      MODE_RANDOM: noise_code = sweep_q;
`endif
      default:     noise_code = '0;
    endcase
  end

  // Burst configuration and remaining-count bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      fixed_q <= '0;
      rem_q   <= '0;
    end else if (accept_start) begin
      mode_q  <= noise_mode_e'(bus.cfg_mode);
      fixed_q <= bus.cfg_fixed;
      rem_q   <= bus.cfg_burst;   // 0 wraps through 255 on the first accept: 256 words
    end else if (hs) begin
      rem_q   <= rem_q - 8'd1;
    end
  end

  // Sweep counter advances only when it supplies a code; wraps naturally at 31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sweep_q <= '0;
    else if (sweep_step) sweep_q <= sweep_q + 1'b1;
  end

  // Single-entry output register: load on accept, clear on drain, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      noise_q <= '0;
    end else if (hs) begin
      valid_q <= 1'b1;
      data_q  <= bus.in_data;
      noise_q <= noise_code;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noise_sequencer.sv
// Self-checking bench for noise_sequencer using a scoreboard queue of expected
// {codeword, noise} pairs. Honours NOISE_SEQ_LFSR_EN for the RANDOM expectation.
module tb_noise_sequencer;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  noise_sequencer_if bus ();

  noise_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  logic [12:0] sb_q[$];
  logic [1:0]  cur_mode;
  logic [4:0]  cur_fixed;
  logic [4:0]  model_sweep = 5'd0;
  logic [7:0]  model_lfsr  = 8'hA5;
  logic [7:0]  model_rem   = 8'd0;

  function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
    logic fb;
    fb = ^(s & 8'hB8);
    return {s[6:0], fb};
  endfunction

  function automatic logic [4:0] next_code();
    logic [4:0] c;
    c = 5'd0;
    case (cur_mode)
      2'd1: c = cur_fixed;
      2'd2: begin c = model_sweep; model_sweep = model_sweep + 5'd1; end
      2'd3: begin
`ifdef NOISE_SEQ_LFSR_EN
        c = model_lfsr[4:0];
        model_lfsr = lfsr_adv(model_lfsr);
`else
        c = model_sweep;
        model_sweep = model_sweep + 5'd1;
`endif
      end
      default: c = 5'd0;
    endcase
    return c;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb_q.delete();
    model_sweep = 5'd0;
    model_lfsr  = 8'hA5;
    model_rem   = 8'd0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [4:0] f, input logic [7:0] b);
    bus.cfg_mode  = m;
    bus.cfg_fixed = f;
    bus.cfg_burst = b;
    bus.start     = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.cfg_mode  = ~m;          // scrambled: the burst must keep the sampled config
    bus.cfg_fixed = ~f;
    bus.cfg_burst = b + 8'd7;
    cur_mode  = m;
    cur_fixed = f;
    model_rem = b;
    model_lfsr = 8'hA5;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL start_busy: got %b want 1", bus.busy);
    end
  endtask

  // Streams n_words through the DUT, scoring every output against the queue.
  // stall_mode: 0 always ready, 1 random ready, 2 hold ready low 5 cycles once.
  task automatic run_stream(input int n_words, input int stall_mode, input int start_at,
                            output int n_out, output int n_done,
                            output int first_hs, output int last_hs,
                            output logic [4:0] last_noise);
    int sent = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled_once = 1'b0;
    bit finished = 1'b0;
    logic [7:0] hold_d = 8'd0;
    logic [4:0] hold_n = 5'd0;
    logic [12:0] item;
    n_out = 0; n_done = 0; first_hs = -1; last_hs = -1; last_noise = 5'd0;
    while (!finished && cyc < 2000) begin
      bus.in_valid = (sent < n_words);
      bus.in_data  = 8'($urandom);
      bus.start    = (cyc == start_at);
      if (stall_mode == 2 && !stalled_once && bus.out_valid) begin
        stall_left = 5; stalled_once = 1'b1;
        hold_d = bus.out_data; hold_n = bus.out_noise;
      end
      case (stall_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = (stall_left == 0);
      endcase
      #1;
      n_checks++;
      if (bus.remaining !== model_rem) begin
        n_bad++; $display("FAIL remaining: got %0d want %0d", bus.remaining, model_rem);
      end
      if (bus.out_valid && !bus.out_ready) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_bad++; $display("FAIL in_ready_stall: got %b want 0", bus.in_ready);
        end
      end
      if (stall_left > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_noise !== hold_n) begin
          n_bad++;
          $display("FAIL hold_stable: got v=%b d=%h n=%h want v=1 d=%h n=%h",
                   bus.out_valid, bus.out_data, bus.out_noise, hold_d, hold_n);
        end
        stall_left--;
      end
      if (sent == n_words) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_bad++; $display("FAIL in_ready_after_last: got %b want 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_bad++; $display("FAIL out_unexpected: got d=%h n=%h want nothing", bus.out_data, bus.out_noise);
        end else begin
          item = sb_q.pop_front();
          if ({bus.out_data, bus.out_noise} !== item) begin
            n_bad++;
            $display("FAIL out_word: got d=%h n=%h want d=%h n=%h",
                     bus.out_data, bus.out_noise, item[12:5], item[4:0]);
          end
        end
        n_out++;
        last_noise = bus.out_noise;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back({bus.in_data, next_code()});
        sent++;
        model_rem = model_rem - 8'd1;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (bus.done) begin
        n_done++;
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_bad++; $display("FAIL busy_in_done: got %b want 0", bus.busy);
        end
      end else if (n_done > 0) begin
        n_checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
          n_bad++; $display("FAIL idle_after_done: got busy=%b in_ready=%b want 0 0", bus.busy, bus.in_ready);
        end
        finished = 1'b1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    n_checks++;
    if (!finished) begin
      n_bad++; $display("FAIL stream_timeout: got %0d cycles want done", cyc);
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.out_noise !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.remaining !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h n=%h busy=%b done=%b rem=%0d want all 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_noise, bus.busy, bus.done, bus.remaining);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fixed_back_to_back();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    do_start(2'd1, 5'h13, 8'd3);
    run_stream(3, 0, -1, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 3 || n_done !== 1) begin
      n_bad++; $display("FAIL fixed_counts: got out=%0d done=%0d want 3 1", n_out, n_done);
    end
    n_checks++;
    if (l_hs - f_hs !== 2) begin
      n_bad++; $display("FAIL fixed_throughput: got span=%0d want 2", l_hs - f_hs);
    end
  endtask

  task automatic test_sweep_wrap();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    apply_reset();
    do_start(2'd2, 5'd0, 8'd0);
    n_checks++;
    if (bus.remaining !== 8'd0) begin
      n_bad++; $display("FAIL burst0_remaining: got %0d want 0", bus.remaining);
    end
    run_stream(256, 0, -1, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 256 || n_done !== 1 || ln !== 5'd31) begin
      n_bad++; $display("FAIL sweep_counts: got out=%0d done=%0d last=%0d want 256 1 31", n_out, n_done, ln);
    end
  endtask

  task automatic test_backpressure();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    do_start(2'd2, 5'd0, 8'd8);
    run_stream(8, 2, -1, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 8 || n_done !== 1 || sb_q.size() !== 0) begin
      n_bad++; $display("FAIL backpressure_counts: got out=%0d done=%0d left=%0d want 8 1 0", n_out, n_done, sb_q.size());
    end
  endtask

  task automatic test_start_ignored();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    do_start(2'd2, 5'd0, 8'd6);
    run_stream(6, 0, 2, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 6 || n_done !== 1) begin
      n_bad++; $display("FAIL start_ignored_counts: got out=%0d done=%0d want 6 1", n_out, n_done);
    end
  endtask

  task automatic test_reset_midburst();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    do_start(2'd2, 5'd0, 8'd10);
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL midburst_loaded: got %b want 1", bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.remaining !== 8'd0 || bus.out_data !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b busy=%b rdy=%b rem=%0d d=%h want 0 0 0 0 00",
               bus.out_valid, bus.busy, bus.in_ready, bus.remaining, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    sb_q.delete();
    model_sweep = 5'd0; model_lfsr = 8'hA5; model_rem = 8'd0;
    do_start(2'd2, 5'd0, 8'd2);
    run_stream(2, 0, -1, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 2 || n_done !== 1 || ln !== 5'd1) begin
      n_bad++; $display("FAIL after_reset_burst: got out=%0d done=%0d last=%0d want 2 1 1", n_out, n_done, ln);
    end
  endtask

  task automatic test_random();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    apply_reset();
    do_start(2'd3, 5'd0, 8'd4);
    run_stream(4, 1, -1, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 4 || n_done !== 1) begin
      n_bad++; $display("FAIL random_counts: got out=%0d done=%0d want 4 1", n_out, n_done);
    end
  endtask

  task automatic test_random_ready_sweep();
    int n_out, n_done, f_hs, l_hs; logic [4:0] ln;
    do_start(2'd2, 5'd0, 8'd20);
    run_stream(20, 1, -1, n_out, n_done, f_hs, l_hs, ln);
    n_checks++;
    if (n_out !== 20 || n_done !== 1 || sb_q.size() !== 0) begin
      n_bad++; $display("FAIL random_ready_counts: got out=%0d done=%0d left=%0d want 20 1 0", n_out, n_done, sb_q.size());
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_fixed = 5'd0; bus.cfg_burst = 8'd0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b1;
    test_reset();
    test_fixed_back_to_back();
    test_sweep_wrap();
    test_backpressure();
    test_start_ignored();
    test_reset_midburst();
    test_random();
    test_random_ready_sweep();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
